// File: rtl/time_field_encoder_if.sv
// Handshake and field bundle between a time-entry source and the encoder.
// The master drives start and the fields; the slave returns status and the result.
interface time_field_encoder_if #(
   parameter int FIELD_W = 10,
   parameter int TIME_W  = 19
);
   logic               start;
   logic [FIELD_W-1:0] minutes;
   logic [FIELD_W-1:0] seconds;
   logic [FIELD_W-1:0] hundreth_sec;
   logic               busy;
   logic               done;
   logic               error;
   logic [TIME_W-1:0]  binary_time;

   modport master (
      output start, minutes, seconds, hundreth_sec,
      input  busy, done, error, binary_time
   );

   modport slave (
      input  start, minutes, seconds, hundreth_sec,
      output busy, done, error, binary_time
   );
endinterface

// File: rtl/time_field_encoder.sv
// Range-checks a min:sec.hund entry and converts it to hundredths of a second
// with a bit-serial shift-add (2*FIELD_W+2 edges for valid input, 1 edge for an error).
module time_field_encoder #(
   parameter int FIELD_W = 10,
   parameter int TIME_W  = 19
) (
   input  logic                clk,
   input  logic                reset,
   time_field_encoder_if.slave bus
);
   localparam int ACC_W = TIME_W + FIELD_W;
   localparam int CNT_W = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;

   typedef enum logic [2:0] {IDLE, CHECK, MUL_MIN, MUL_SEC, ADD} state_t;

   state_t             state;
   logic [FIELD_W-1:0] min_r;
   logic [FIELD_W-1:0] sec_r;
   logic [FIELD_W-1:0] hund_r;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               busy_q;
   logic               done_q;
   logic               error_q;
   logic [TIME_W-1:0]  time_q;

   logic               last_bit;
   logic               range_bad;
   logic [ACC_W-1:0]   min_term;
   logic [ACC_W-1:0]   sec_term;

   assign last_bit  = (cnt == CNT_W'(FIELD_W - 1));
   assign range_bad = (min_r > FIELD_W'(59)) || (sec_r > FIELD_W'(59)) ||
                      (hund_r > FIELD_W'(99));
   assign min_term  = ACC_W'(6000) << cnt;
   assign sec_term  = ACC_W'(100) << cnt;

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.error       = error_q;
   assign bus.binary_time = time_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         min_r   <= '0;
         sec_r   <= '0;
         hund_r  <= '0;
         acc     <= '0;
         cnt     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         time_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  min_r   <= bus.minutes;
                  sec_r   <= bus.seconds;
                  hund_r  <= bus.hundreth_sec;
                  acc     <= '0;
                  cnt     <= '0;
                  error_q <= 1'b0;
                  time_q  <= '0;
                  busy_q  <= 1'b1;
                  state   <= CHECK;
               end
            end
            CHECK: begin
               if (range_bad) begin
                  done_q  <= 1'b1;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  cnt   <= '0;
                  state <= MUL_MIN;
               end
            end
            MUL_MIN: begin
               if (min_r[cnt]) acc <= acc + min_term;
               if (last_bit) begin
                  cnt   <= '0;
                  state <= MUL_SEC;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            MUL_SEC: begin
               if (sec_r[cnt]) acc <= acc + sec_term;
               if (last_bit) begin
                  cnt   <= '0;
                  state <= ADD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ADD: begin
               // Range check bounds the sum well inside TIME_W, so truncation is lossless.
               time_q  <= TIME_W'(acc + ACC_W'(hund_r));
               done_q  <= 1'b1;
               error_q <= 1'b0;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_time_field_encoder.sv
// Directed-vector bench for time_field_encoder: latency, results, range errors,
// ignored restarts, mid-conversion reset and back-to-back operation.
module tb_time_field_encoder;
   logic clk;
   logic reset;
   int   assertions;
   int   failures;

   time_field_encoder_if #(.FIELD_W(10), .TIME_W(19)) bus ();

   time_field_encoder #(.FIELD_W(10), .TIME_W(19)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Leaves the caller just after the start-sampling edge (edge 0).
   task automatic start_conv(input int m, input int s, input int h);
      @(negedge clk);
      bus.minutes      = 10'(m);
      bus.seconds      = 10'(s);
      bus.hundreth_sec = 10'(h);
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Returns the edge index at which done became visible, and the busy cycles before it.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (bus.done !== 1'b1 && lat < 100) begin
         if (bus.busy === 1'b1) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      assertions++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      assertions++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", bus.done); end
      assertions++; if (bus.error !== 1'b0) begin failures++; $display("FAIL reset_error got %b want 0", bus.error); end
      assertions++; if (bus.binary_time !== 19'd0) begin failures++; $display("FAIL reset_time got %0d want 0", bus.binary_time); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int lat, bcnt;
      start_conv(12, 34, 56);
      wait_done(lat, bcnt);
      assertions++; if (lat !== 22) begin failures++; $display("FAIL basic_latency got %0d want 22", lat); end
      assertions++; if (bcnt !== 22) begin failures++; $display("FAIL basic_busy_cycles got %0d want 22", bcnt); end
      assertions++; if (bus.binary_time !== 19'd75456) begin failures++; $display("FAIL basic_time got %0d want 75456", bus.binary_time); end
      assertions++; if (bus.error !== 1'b0) begin failures++; $display("FAIL basic_error got %b want 0", bus.error); end
      assertions++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got %b want 0", bus.busy); end
      @(negedge clk);
      assertions++; if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_done_width got %b want 0", bus.done); end
      assertions++; if (bus.binary_time !== 19'd75456) begin failures++; $display("FAIL basic_time_hold got %0d want 75456", bus.binary_time); end
   endtask

   task automatic test_boundary;
      int lat, bcnt;
      start_conv(59, 59, 99);
      wait_done(lat, bcnt);
      assertions++; if (bus.binary_time !== 19'h57E3F) begin failures++; $display("FAIL max_time got %0d want 359999", bus.binary_time); end
      assertions++; if (bus.error !== 1'b0) begin failures++; $display("FAIL max_error got %b want 0", bus.error); end
      start_conv(0, 0, 0);
      wait_done(lat, bcnt);
      assertions++; if (lat !== 22) begin failures++; $display("FAIL zero_latency got %0d want 22", lat); end
      assertions++; if (bus.binary_time !== 19'd0) begin failures++; $display("FAIL zero_time got %0d want 0", bus.binary_time); end
      assertions++; if (bus.error !== 1'b0) begin failures++; $display("FAIL zero_error got %b want 0", bus.error); end
   endtask

   task automatic test_range;
      int lat, bcnt;
      int vec [3][3];
      vec = '{'{0, 60, 0}, '{60, 0, 0}, '{0, 0, 100}};
      for (int k = 0; k < 3; k++) begin
         start_conv(vec[k][0], vec[k][1], vec[k][2]);
         wait_done(lat, bcnt);
         assertions++; if (lat !== 1) begin failures++; $display("FAIL range%0d_latency got %0d want 1", k, lat); end
         assertions++; if (bus.error !== 1'b1) begin failures++; $display("FAIL range%0d_error got %b want 1", k, bus.error); end
         assertions++; if (bus.binary_time !== 19'd0) begin failures++; $display("FAIL range%0d_time got %0d want 0", k, bus.binary_time); end
      end
      @(negedge clk);
      assertions++; if (bus.error !== 1'b1) begin failures++; $display("FAIL range_error_hold got %b want 1", bus.error); end
      start_conv(0, 0, 1);
      assertions++; if (bus.error !== 1'b0) begin failures++; $display("FAIL range_error_clear got %b want 0", bus.error); end
      wait_done(lat, bcnt);
      assertions++; if (bus.binary_time !== 19'd1) begin failures++; $display("FAIL range_recover_time got %0d want 1", bus.binary_time); end
   endtask

   task automatic test_ignore_restart;
      int dn, first;
      logic [18:0] bt;
      dn = 0; first = -1; bt = '0;
      start_conv(1, 0, 0);
      for (int c = 1; c <= 60; c++) begin
         if (c == 4) begin
            bus.minutes = 10'd30; bus.seconds = 10'd30; bus.hundreth_sec = 10'd30;
            bus.start = 1'b1;
         end
         if (c == 5) bus.start = 1'b0;
         @(negedge clk);
         if (bus.done === 1'b1) begin
            dn++;
            if (first < 0) begin first = c; bt = bus.binary_time; end
         end
      end
      assertions++; if (dn !== 1) begin failures++; $display("FAIL ignore_done_count got %0d want 1", dn); end
      assertions++; if (first !== 22) begin failures++; $display("FAIL ignore_latency got %0d want 22", first); end
      assertions++; if (bt !== 19'd6000) begin failures++; $display("FAIL ignore_time got %0d want 6000", bt); end
   endtask

   task automatic test_reset_mid;
      int lat, bcnt, dn;
      start_conv(12, 34, 56);
      repeat (15) @(negedge clk);
      assertions++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before got %b want 1", bus.busy); end
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      assertions++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
      assertions++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midreset_done got %b want 0", bus.done); end
      assertions++; if (bus.binary_time !== 19'd0) begin failures++; $display("FAIL midreset_time got %0d want 0", bus.binary_time); end
      dn = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) dn++;
      end
      assertions++; if (dn !== 0) begin failures++; $display("FAIL midreset_ghost_done got %0d want 0", dn); end
      start_conv(0, 5, 7);
      wait_done(lat, bcnt);
      assertions++; if (lat !== 22) begin failures++; $display("FAIL midreset_new_latency got %0d want 22", lat); end
      assertions++; if (bus.binary_time !== 19'd507) begin failures++; $display("FAIL midreset_new_time got %0d want 507", bus.binary_time); end
   endtask

   task automatic test_back_to_back;
      int dn;
      int edges [$];
      dn = 0;
      @(negedge clk);
      bus.minutes = 10'd0; bus.seconds = 10'd0; bus.hundreth_sec = 10'd1;
      bus.start = 1'b1;
      for (int e = 0; e < 75; e++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            dn++;
            edges.push_back(e);
            assertions++; if (bus.binary_time !== 19'd1) begin failures++; $display("FAIL b2b_time edge %0d got %0d want 1", e, bus.binary_time); end
            assertions++; if (bus.error !== 1'b0) begin failures++; $display("FAIL b2b_error edge %0d got %b want 0", e, bus.error); end
         end
      end
      bus.start = 1'b0;
      assertions++; if (dn !== 3) begin failures++; $display("FAIL b2b_done_count got %0d want 3", dn); end
      if (dn >= 3) begin
         assertions++; if (edges[0] !== 22) begin failures++; $display("FAIL b2b_first_edge got %0d want 22", edges[0]); end
         assertions++; if (edges[1] - edges[0] !== 23) begin failures++; $display("FAIL b2b_period1 got %0d want 23", edges[1] - edges[0]); end
         assertions++; if (edges[2] - edges[1] !== 23) begin failures++; $display("FAIL b2b_period2 got %0d want 23", edges[2] - edges[1]); end
      end
      repeat (30) @(negedge clk);
   endtask

   initial begin
      assertions       = 0;
      failures         = 0;
      reset            = 1'b0;
      bus.start        = 1'b0;
      bus.minutes      = '0;
      bus.seconds      = '0;
      bus.hundreth_sec = '0;
      test_reset();
      test_basic();
      test_boundary();
      test_range();
      test_ignore_restart();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
